// File: rtl/matrix_loader_pkg.sv
// matrix_loader_pkg: shared definitions for the 2x2 matrix loader and multiplier.
// Holds the loader FSM encoding, operand index map and default element width.
package matrix_loader_pkg;

    // Default operand element width, shared with the multiplier a/b inputs.
    localparam int DATA_W_DEF = 8;

    // Elements per matrix pair and index width.
    localparam int N_ELEM = 8;
    localparam int IDX_W  = 3;

    // Stream order: a11,a12,a21,a22,b11,b12,b21,b22.
    localparam logic [IDX_W-1:0] IDX_A11 = 3'd0;
    localparam logic [IDX_W-1:0] IDX_A12 = 3'd1;
    localparam logic [IDX_W-1:0] IDX_A21 = 3'd2;
    localparam logic [IDX_W-1:0] IDX_A22 = 3'd3;
    localparam logic [IDX_W-1:0] IDX_B11 = 3'd4;
    localparam logic [IDX_W-1:0] IDX_B12 = 3'd5;
    localparam logic [IDX_W-1:0] IDX_B21 = 3'd6;
    localparam logic [IDX_W-1:0] IDX_B22 = 3'd7;

    // Loader FSM encoding.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } ml_state_e;

    // Next element index; wraps from IDX_B22 back to IDX_A11.
    function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/matrix_loader.sv
// matrix_loader: collects eight streamed elements into registered 2x2 operands
// a/b, pulses start for the multiplier, then waits for mm_done.
// Ports:
//   clk, rst_n (async, active-low)     - clock and reset
//   in_valid, in_data, in_ready        - element stream handshake
//   flush                              - synchronous abort; clears operands and err
//   a11..a22, b11..b22                 - registered operands for the multiplier
//   start                              - one-cycle launch pulse
//   mm_done                            - multiplier completion, honoured in WAIT only
//   busy                               - high in FIRE and WAIT
//   err                                - sticky done-timeout flag
// Build option: MATLOAD_TIMEOUT_EN adds a WAIT-state timeout of TIMEOUT_CYCLES
// that sets err and returns to LOAD; without it err is tied 0.
module matrix_loader
    import matrix_loader_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] a11,
    output logic [DATA_W-1:0] a12,
    output logic [DATA_W-1:0] a21,
    output logic [DATA_W-1:0] a22,
    output logic [DATA_W-1:0] b11,
    output logic [DATA_W-1:0] b12,
    output logic [DATA_W-1:0] b21,
    output logic [DATA_W-1:0] b22,
    output logic              start,
    input  logic              mm_done,
    output logic              busy,
    output logic              err
);

    ml_state_e         r_state;
    ml_state_e         w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_op [N_ELEM];

    logic w_in_ready;
    logic w_xfer;
    logic w_last;
    logic w_to_hit;

    // in_ready is gated by rst_n so it reads 0 throughout reset, and by
    // flush so an abort cycle never accepts an element.
    assign w_in_ready = rst_n && (r_state == LOAD) && !flush;
    assign w_xfer     = in_valid && w_in_ready;
    assign w_last     = (r_idx == IDX_B22);

    assign in_ready = w_in_ready;
    assign start    = (r_state == FIRE) && !flush;
    assign busy     = (r_state == FIRE) || (r_state == WAIT);

    assign a11 = r_op[IDX_A11];
    assign a12 = r_op[IDX_A12];
    assign a21 = r_op[IDX_A21];
    assign a22 = r_op[IDX_A22];
    assign b11 = r_op[IDX_B11];
    assign b12 = r_op[IDX_B12];
    assign b21 = r_op[IDX_B21];
    assign b22 = r_op[IDX_B22];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. mm_done only matters in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = LOAD;
        end else begin
            unique case (r_state)
                LOAD: begin
                    if (w_xfer && w_last) begin
                        w_state_nxt = FIRE;
                    end
                end
                FIRE: begin
                    w_state_nxt = WAIT;
                end
                WAIT: begin
                    if (mm_done || w_to_hit) begin
                        w_state_nxt = LOAD;
                    end
                end
                default: begin
                    w_state_nxt = LOAD;
                end
            endcase
        end
    end

    // Index and operand registers. Operands only change on their own
    // transfer, which can only happen in LOAD, so they hold through
    // FIRE and WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            for (int i = 0; i < N_ELEM; i++) begin
                r_op[i] <= '0;
            end
        end else if (flush) begin
            r_idx <= '0;
            for (int i = 0; i < N_ELEM; i++) begin
                r_op[i] <= '0;
            end
        end else if (w_xfer) begin
            r_op[r_idx] <= in_data;
            r_idx       <= idx_next(r_idx);
        end
    end

`ifdef MATLOAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    // The counter sits at 0 outside WAIT, so every WAIT entry starts from 0.
    // Hit fires on the TIMEOUT_CYCLES-th edge spent in WAIT.
    assign w_to_hit = (r_state == WAIT) &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign err      = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else if (flush) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if ((r_state != WAIT) || w_to_hit || mm_done) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            // A done on the timeout edge is a normal completion.
            if (w_to_hit && !mm_done) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_to_hit     = 1'b0;
    assign err          = 1'b0;
    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: scoreboard bench for matrix_loader; expected operand sets
// are queued from accepted handshakes and popped on each start pulse.
module tb_matrix_loader;
    import matrix_loader_pkg::*;

    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          flush    = 1'b0;
    logic          mm_done  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a11, a12, a21, a22, b11, b12, b21, b22;
    logic          start, busy, err;

    matrix_loader #(
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .flush    (flush),
        .a11      (a11),
        .a12      (a12),
        .a21      (a21),
        .a22      (a22),
        .b11      (b11),
        .b12      (b12),
        .b21      (b21),
        .b22      (b22),
        .start    (start),
        .mm_done  (mm_done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ops_vec();
        return {a11, a12, a21, a22, b11, b12, b21, b22};
    endfunction

    // Scoreboard monitor: mirrors accepted elements and predicts start.
    logic [63:0]   exp_q [$];
    logic [DW-1:0] m_buf [8];
    int            m_n        = 0;
    int            cyc        = 0;
    int            exp_start  = -1;
    int            n_start    = 0;
    int            last_start = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n       = 0;
            exp_start = -1;
            exp_q.delete();
        end else begin
            cyc++;
            if (start || cyc == exp_start) begin
                check("start_cyc", start ? cyc : -2, exp_start);
                if (start) begin
                    n_start++;
                    last_start = cyc;
                    if (exp_q.size() > 0)
                        check("operands", ops_vec(), exp_q.pop_front());
                    else
                        check("sb_pending", exp_q.size(), 1);
                end
            end
            if (flush) begin
                check("flush_rdy", in_ready, 0);
                m_n = 0;
            end else if (in_valid && in_ready) begin
                m_buf[m_n] = in_data;
                m_n++;
                if (m_n == 8) begin
                    exp_q.push_back({m_buf[0], m_buf[1], m_buf[2], m_buf[3],
                                     m_buf[4], m_buf[5], m_buf[6], m_buf[7]});
                    exp_start = cyc + 1;
                    m_n       = 0;
                end
            end
        end
    end

    // Offer one element and return #1 after the edge that accepts it.
    task automatic send(input logic [DW-1:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("send_timeout", n, 0);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [DW-1:0] base, input int cnt);
        for (int i = 0; i < cnt; i++) send(base + DW'(i));
    endtask

    // Wait for one start pulse within a bound, then verify exactly one seen.
    task automatic wait_start(input int s0);
        int n;
        n = 0;
        while (n_start == s0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        check("one_start", n_start - s0, 1);
    endtask

    task automatic pulse_done();
        mm_done = 1'b1;
        @(posedge clk);
        #1;
        mm_done = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] first_ops;
    int          t0, d1, d2, s0, n;

    initial begin
        // Reset state.
        #12;
        check("rst_ready", in_ready, 0);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_ops", ops_vec(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rel_ready", in_ready, 1);

        // Basic stream and chained multiply.
        @(posedge clk);
        #1;
        t0 = cyc;
        s0 = n_start;
        send(8'd2); send(8'd3); send(8'd4); send(8'd5);
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        wait_start(s0);
        d1 = last_start - t0;
        check("lat1", d1, 9);
        check("wait_busy", busy, 1);
        check("c11", a11 * b11 + a12 * b21, 11);
        check("c12", a11 * b12 + a12 * b22, 16);
        check("c21", a21 * b11 + a22 * b21, 19);
        check("c22", a21 * b12 + a22 * b22, 28);
        first_ops = ops_vec();

        // Second matrix offered while waiting.
        in_valid = 1'b1;
        in_data  = 8'd9;
        repeat (4) begin
            @(negedge clk);
            check("wait_rdy", in_ready, 0);
            check("wait_hold", ops_vec(), first_ops);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pulse_done();
        check("done_busy", busy, 0);
        check("done_rdy", in_ready, 1);
        s0 = n_start;
        send(8'd10);
        check("one_elem", {a11, a12, b22}, {8'd10, 8'd3, 8'd4});
        send_seq(8'd11, 7);
        wait_start(s0);
        pulse_done();

        // Stall of 3 cycles after the 4th element; done ignored in LOAD.
        t0 = cyc;
        s0 = n_start;
        send(8'd2); send(8'd3); send(8'd4); send(8'd5);
        mm_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mm_done = 1'b0;
        check("stall_hold", ops_vec(), 64'h02030405_0e0f1011);
        check("stall_busy", busy, 0);
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        wait_start(s0);
        d2 = last_start - t0;
        check("stall_lat", d2, d1 + 3);
        pulse_done();

        // Flush after 5 elements.
        send_seq(8'd20, 5);
        in_valid = 1'b1;
        in_data  = 8'h99;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_ops", ops_vec(), 0);
        s0 = n_start;
        send_seq(8'd1, 8);
        wait_start(s0);
        check("flush_new", ops_vec(), 64'h01020304_05060708);
        pulse_done();

        // Reset mid-matrix.
        send_seq(8'd30, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ops", ops_vec(), 0);
        check("arst_rdy", in_ready, 0);
        check("arst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("arst_rel", in_ready, 1);
        s0 = n_start;
        send_seq(8'd40, 8);
        wait_start(s0);
        pulse_done();

        // Missing done.
        s0 = n_start;
        send_seq(8'd50, 8);
        wait_start(s0);
`ifdef MATLOAD_TIMEOUT_EN
        // wait_start returns one edge past WAIT entry.
        n = 1;
        while (!err && n < 3 * TO) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("to_lat", n, TO);
        check("to_busy", busy, 0);
        check("to_rdy", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        check("to_sticky", err, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("to_clr", err, 0);
`else
        repeat (2 * TO) @(posedge clk);
        #1;
        check("no_to_err", err, 0);
        check("no_to_busy", busy, 1);
        pulse_done();
        check("no_to_done", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
